hilo_muldiv: RTL and testbench
==============================

# hilo_muldiv

Parametrised HI/LO special-register unit for the RISC core. It runs iterative signed and unsigned multiply and divide, and services MTHI/MTLO writes. The HI/LO pair are held as registered state and read by the writeback mux. It replaces plain clocked HI/LO latching with a multi-cycle engine and a start/busy/done handshake.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO register width; must be ≥ 4 and even.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  request strobe; sampled only while idle (busy=0).
- op  in  3  operation: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6 and 7 are ignored.
- a  in  WIDTH  multiplicand/dividend, or the MTHI/MTLO write data.
- b  in  WIDTH  multiplier/divisor.
- busy  out  1  engine is mid-operation.
- done  out  1  one-cycle pulse when HI/LO take a mul/div result.
- div_by_zero  out  1  pulses with done when a DIV/DIVU had b=0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN, FIX.
- Reset values: state=IDLE; hi, lo = 0; busy, done, div_by_zero = 0; internal counter and accumulators = 0.
- IDLE, start=1, op MULT/MULTU/DIV/DIVU:
  - latch operands, go to RUN, set counter = WIDTH-1.
  - for signed ops, latch absolute values and record the result signs.
- IDLE, start=1, op MTHI: hi<=a at the next edge; lo unchanged; stay IDLE; no busy, no done.
- IDLE, start=1, op MTLO: lo<=a at the next edge; hi unchanged; stay IDLE; no busy, no done.
- IDLE, start=1, op 6 or 7: no effect.
- RUN, multiply: one shift-add step per cycle on a 2·WIDTH product register.
- RUN, divide: one restoring step per cycle, giving quotient and remainder bits.
- RUN exit: after WIDTH steps (counter reaches 0), go to FIX.
- FIX: apply sign correction, write hi/lo, pulse done, go to IDLE.
- Multiply result: {hi, lo} = the full 2·WIDTH product, two's complement for MULT.
- Divide result: lo = quotient truncated toward zero; hi = remainder.
  - For DIV the remainder takes the sign of the dividend.
- Divide by zero:
  - no early exit; full latency.
  - hi = a as presented; lo = all ones; div_by_zero=1 with done.
- DIV overflow (most negative / -1): lo = most negative value, hi = 0; no flag.
- start while busy=1 is ignored; op/a/b may change freely after acceptance.
- hi/lo hold their previous values for the whole RUN period.
- rst in any state: immediate return to IDLE, hi/lo cleared, no done; the in-flight operation is discarded.

## Timing
- Request sampled at edge E0 goes to RUN.
- busy=1 from after E0 until after edge E0+WIDTH+1.
- hi/lo updated, done=1 and busy=0 together, in the cycle after edge E0+WIDTH+1.
- Mul/div latency is therefore WIDTH+2 cycles from start to result visible, independent of operand values.
- A new start is accepted in the same cycle that done=1 is high (the unit is already IDLE).
- done and div_by_zero are high for exactly one cycle.
- MTHI/MTLO: value visible on hi/lo in the cycle after the accepting edge.
- A simultaneous start and rst is ignored.

## Structure
- Shared package hilo_pkg holds:
  - op encodings as a 3-bit enum: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO.
  - the state enum: S_IDLE, S_RUN, S_FIX.
- Single module, no sub-module.
  - The multiply and divide paths share the counter, sign flags and the 2·WIDTH accumulator.
  - Splitting them out adds only port plumbing.

## Test plan
All scenarios run with WIDTH=32.
- Reset, then MULTU a=0xFFFFFFFF b=2 → done exactly 34 cycles after start; hi=0x00000001, lo=0xFFFFFFFE.
- MULT a=-3 b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV a=-7 b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Then DIVU with the same operands → lo=0x7FFFFFFC, hi=0x00000001.
- DIVU a=100 b=0 → hi=0x00000064, lo=0xFFFFFFFF, div_by_zero=1 for one cycle.
  - Then DIV a=0x80000000 b=-1 → lo=0x80000000, hi=0, no flag.
- MTHI a=0x1234 → hi=0x1234 next cycle with lo unchanged; MTLO a=0x5678 → lo=0x5678.
  - During a MULT's RUN phase, issue start with MTHI → ignored; hi is only the product.
- Assert rst 10 cycles into a DIVU → next cycle busy=0, hi=lo=0, no done pulse.
  - A MULTU started the cycle after rst deasserts completes normally with the correct product.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: operation codes and engine states.
package hilo_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/hilo_muldiv.sv
// HI/LO register pair with an iterative shift-add multiplier and restoring divider.
// Mul/div results land WIDTH+2 cycles after start; MTHI/MTLO write in one cycle.
module hilo_muldiv
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [W2-1:0]  acc_q;
  logic [WIDTH-1:0] opd_q;
  logic           is_div_q, neg_res_q, neg_rem_q, dbz_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic           busy_q, done_q, dbz_out_q;

  logic             is_signed;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum, div_trial, div_diff;
  logic [W2-1:0]    acc_d, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix, res_hi_d, res_lo_d;

  always_comb begin
    is_signed = (op_e'(op) == OP_MULT) || (op_e'(op) == OP_DIV);
    abs_a     = (is_signed && a[WIDTH-1]) ? -a : a;
    abs_b     = (is_signed && b[WIDTH-1]) ? -b : b;
  end

  // acc_q holds {upper, lower}: product/multiplier for mul, remainder/quotient for div.
  always_comb begin
    mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    div_trial = acc_q[W2-1:WIDTH-1];
    div_diff  = div_trial - {1'b0, opd_q};
    acc_d     = {mul_sum, acc_q[WIDTH-1:1]};
    if (is_div_q) begin
      if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                  acc_d = {acc_q[W2-2:0], 1'b0};
    end
  end

  // With a zero divisor every step shifts, so the remainder ends up as |a| and the
  // sign correction restores a itself.
  always_comb begin
    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
    res_hi_d = prod_fix[W2-1:WIDTH];
    res_lo_d = prod_fix[WIDTH-1:0];
    if (is_div_q) begin
      res_hi_d = rem_fix;
      res_lo_d = dbz_q ? '1 : quo_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opd_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            case (op_e'(op))
              OP_MULT, OP_MULTU: begin
                acc_q     <= {{WIDTH{1'b0}}, abs_b};
                opd_q     <= abs_a;
                is_div_q  <= 1'b0;
                neg_res_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_rem_q <= 1'b0;
                dbz_q     <= 1'b0;
                cnt_q     <= CW'(WIDTH - 1);
                busy_q    <= 1'b1;
                state_q   <= S_RUN;
              end
              OP_DIV, OP_DIVU: begin
                acc_q     <= {{WIDTH{1'b0}}, abs_a};
                opd_q     <= abs_b;
                is_div_q  <= 1'b1;
                neg_res_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_rem_q <= is_signed && a[WIDTH-1];
                dbz_q     <= (b == '0);
                cnt_q     <= CW'(WIDTH - 1);
                busy_q    <= 1'b1;
                state_q   <= S_RUN;
              end
              OP_MTHI: hi_q <= a;
              OP_MTLO: lo_q <= a;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= S_FIX;
        end
        S_FIX: begin
          hi_q      <= res_hi_d;
          lo_q      <= res_lo_d;
          done_q    <= 1'b1;
          dbz_out_q <= dbz_q;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_out_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed + random checks of hilo_muldiv (WIDTH=32) against a scoreboard of expected HI/LO.
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] ph, pl;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        m;
    longint      sx, sy, q, r;
    logic [63:0] p, qv, rv;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    m  = '0;
    case (o)
      3'd0: begin p = sx * sy; m.hi = p[63:32]; m.lo = p[31:0]; end
      3'd1: begin p = {32'h0, x} * {32'h0, y}; m.hi = p[63:32]; m.lo = p[31:0]; end
      default: begin
        if (y == 32'h0) begin
          m.hi = x; m.lo = 32'hFFFF_FFFF; m.dbz = 1'b1;
        end else if (o == 3'd2) begin
          q = sx / sy; r = sx % sy; qv = q; rv = r;
          m.lo = qv[31:0]; m.hi = rv[31:0];
        end else begin
          qv = {32'h0, x} / {32'h0, y}; rv = {32'h0, x} % {32'h0, y};
          m.lo = qv[31:0]; m.hi = rv[31:0];
        end
      end
    endcase
    return m;
  endfunction

  // Called just after a falling edge; returns one falling edge after the accepting edge.
  task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input exp_t e);
    ph = hi; pl = lo;
    start = 1'b1; op = o; a = x; b = y;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; op = 3'd6; a = $urandom; b = $urandom;
  endtask

  task automatic finish_op(input string tag, input int lat0);
    int   lat;
    logic held;
    exp_t e;
    lat  = lat0;
    held = 1'b1;
    check({tag, "_busy_early"}, {done, div_by_zero, busy}, 3'b001);
    while (done !== 1'b1 && lat < 60) begin
      if (hi !== ph || lo !== pl) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 34);
    if (lat0 == 1) check({tag, "_hold"}, held, 1'b1);
    e = sb.pop_front();
    check({tag, "_hi"}, hi, e.hi);
    check({tag, "_lo"}, lo, e.lo);
    check({tag, "_dbz"}, div_by_zero, e.dbz);
    check({tag, "_busy_done"}, busy, 1'b0);
  endtask

  initial begin
    exp_t e;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b1; op = 3'd4; a = 32'hFFFF; b = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_flags", {busy, done, div_by_zero}, 3'b000);

    launch(3'd1, 32'hFFFF_FFFF, 32'd2, '{32'h1, 32'hFFFF_FFFE, 1'b0});
    finish_op("multu", 1);
    launch(3'd0, -32'sd3, 32'd5, '{32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0});
    finish_op("mult_neg", 1);
    launch(3'd2, -32'sd7, 32'd2, '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
    finish_op("div_neg", 1);
    launch(3'd3, -32'sd7, 32'd2, '{32'h1, 32'h7FFF_FFFC, 1'b0});
    finish_op("divu", 1);
    launch(3'd3, 32'd100, 32'd0, '{32'h64, 32'hFFFF_FFFF, 1'b1});
    finish_op("divu_zero", 1);
    launch(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, '{32'h0, 32'h8000_0000, 1'b0});
    finish_op("div_ovf", 1);
    check("dbz_one_cycle_prev", div_by_zero, 1'b0);

    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'h1234;
    @(negedge clk);
    start = 1'b0;
    check("mthi_hi", hi, 32'h1234);
    check("mthi_lo_kept", lo, 32'h8000_0000);
    check("mthi_busy", {busy, done}, 2'b00);
    start = 1'b1; op = 3'd5; a = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_lo", lo, 32'h5678);
    check("mtlo_hi_kept", hi, 32'h1234);

    launch(3'd0, 32'd7, -32'sd2, '{32'hFFFF_FFFF, 32'hFFFF_FFF2, 1'b0});
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'hDEAD;
    @(negedge clk);
    start = 1'b0;
    finish_op("mthi_ignored", 5);

    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 5) ? 32'h0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
      e  = model(ro, ra, rb);
      launch(ro, ra, rb, e);
      finish_op($sformatf("rand%0d_op%0d", i, ro), 1);
    end

    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_hilo", {hi, lo}, 64'h0);
    check("rst_mid_done", {done, div_by_zero}, 2'b00);
    @(negedge clk);
    check("rst_mid_no_late_done", done, 1'b0);
    launch(3'd1, 32'h0001_0000, 32'h0001_0003, model(3'd1, 32'h0001_0000, 32'h0001_0003));
    finish_op("multu_after_rst", 1);

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
